// File: rtl/vga_text_cursor_writer_if.sv
// Purpose: byte-stream input and character/attribute cell-write bundle for the text cursor writer.
// Latency: none, wires only.
// Backpressure: in_ready_o from the slave side stalls the byte stream; the write side has no stall.
interface vga_text_cursor_writer_if #(
  parameter int ADDR_W = 12,
  parameter int ATTR_W = 8
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [7:0]        in_char_i;
  logic [ATTR_W-1:0] in_attr_i;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_char_o;
  logic [ATTR_W-1:0] mem_attr_o;

  // Writer side: consumes bytes, drives RAM writes.
  modport slave (
    input  in_valid_i, in_char_i, in_attr_i,
    output in_ready_o, mem_we_o, mem_addr_o, mem_char_o, mem_attr_o
  );

  // Feeder/RAM side.
  modport master (
    output in_valid_i, in_char_i, in_attr_i,
    input  in_ready_o, mem_we_o, mem_addr_o, mem_char_o, mem_attr_o
  );
endinterface

// File: rtl/vga_text_cursor_writer.sv
// Purpose: text cursor that turns a char/control byte stream into 80x30 cell RAM writes.
// Latency: one cycle from byte acceptance to registered write; clear issues COLS*ROWS writes.
// Backpressure: in_ready_o low during reset and CLEAR. Optional VGA_WRITER_CLEAR_ON_RESET_EN blanks RAM after reset.
module vga_text_cursor_writer #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12,
  parameter int ATTR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  vga_text_cursor_writer_if.slave  bus,
  output logic [6:0]               cur_x_o,
  output logic [4:0]               cur_y_o,
  output logic                     busy_o
);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CELLS  = CNT_W'(COLS * ROWS);
  localparam logic [6:0]       X_LAST = 7'(COLS - 1);
  localparam logic [4:0]       Y_LAST = 5'(ROWS - 1);
  localparam logic [ATTR_W-1:0] ATTR_RST = ATTR_W'(8'h0F);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

`ifdef VGA_WRITER_CLEAR_ON_RESET_EN
  localparam state_t STATE_RST = S_CLEAR;
`else
  localparam state_t STATE_RST = S_IDLE;
`endif

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [6:0]        x_q, x_d;
  logic [4:0]        y_q, y_d;
  logic [ATTR_W-1:0] attr_q, attr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        char_q, char_d;
  logic [ATTR_W-1:0] wattr_q, wattr_d;
  logic              accept;
  logic              printable;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] x, input logic [4:0] y);
    return ADDR_W'(y) * ADDR_W'(COLS) + ADDR_W'(x);
  endfunction

  assign bus.in_ready_o = (state_q == S_IDLE) && !rst;
  assign accept         = bus.in_valid_i && bus.in_ready_o;
  assign printable      = !((bus.in_char_i < 8'h20) || (bus.in_char_i == 8'h7F));
  assign busy_o         = (state_q == S_CLEAR) && !rst;
  assign bus.mem_we_o   = we_q;
  assign bus.mem_addr_o = addr_q;
  assign bus.mem_char_o = char_q;
  assign bus.mem_attr_o = wattr_q;
  assign cur_x_o        = x_q;
  assign cur_y_o        = y_q;

  // State register; reset aborts any clear in progress.
  always_ff @(posedge clk) begin
    if (rst) state_q <= STATE_RST;
    else     state_q <= state_d;
  end

  // Next state: form feed starts a clear, clear ends one cycle after its last write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && bus.in_char_i == 8'h0C) state_d = S_CLEAR;
      S_CLEAR: if (clr_cnt_q == CELLS) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: next write, cursor move and clear progress for the coming edge.
  always_comb begin
    we_d      = 1'b0;
    addr_d    = '0;
    char_d    = '0;
    wattr_d   = '0;
    x_d       = x_q;
    y_d       = y_q;
    attr_d    = attr_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          attr_d = bus.in_attr_i;
          if (printable) begin
            we_d    = 1'b1;
            addr_d  = cell_addr(x_q, y_q);
            char_d  = bus.in_char_i;
            wattr_d = bus.in_attr_i;
            if (x_q == X_LAST) begin
              x_d = 7'd0;
              y_d = (y_q == Y_LAST) ? 5'd0 : y_q + 5'd1;
            end else begin
              x_d = x_q + 7'd1;
            end
          end else begin
            case (bus.in_char_i)
              8'h0A: begin
                x_d = 7'd0;
                y_d = (y_q == Y_LAST) ? 5'd0 : y_q + 5'd1;
              end
              8'h0D: x_d = 7'd0;
              8'h08: begin
                if (x_q != 7'd0) begin
                  x_d     = x_q - 7'd1;
                  we_d    = 1'b1;
                  addr_d  = cell_addr(x_q - 7'd1, y_q);
                  char_d  = 8'h20;
                  wattr_d = bus.in_attr_i;
                end
              end
              // Cell 0 is written on the accept edge so the first write lands next cycle.
              8'h0C: begin
                we_d      = 1'b1;
                addr_d    = '0;
                char_d    = 8'h20;
                wattr_d   = bus.in_attr_i;
                clr_cnt_d = CNT_W'(1);
              end
              default: ;
            endcase
          end
        end
      end
      S_CLEAR: begin
        if (clr_cnt_q == CELLS) begin
          x_d       = 7'd0;
          y_d       = 5'd0;
          clr_cnt_d = '0;
        end else begin
          we_d      = 1'b1;
          addr_d    = clr_cnt_q[ADDR_W-1:0];
          char_d    = 8'h20;
          wattr_d   = attr_q;
          clr_cnt_d = clr_cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers: cursor, latched attribute, clear counter and write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= 7'd0;
      y_q       <= 5'd0;
      attr_q    <= ATTR_RST;
      clr_cnt_q <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      char_q    <= '0;
      wattr_q   <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      attr_q    <= attr_d;
      clr_cnt_q <= clr_cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      char_q    <= char_d;
      wattr_q   <= wattr_d;
    end
  end
endmodule
